cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1 (rising-edge clock); reset in 1 (async, active-high).
REQ-002 The block SHALL have these register enable inputs, each 1 bit: PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable.
REQ-003 The block SHALL have memory control inputs read in 1 and write in 1.
REQ-004 The block SHALL have register-field select inputs, each 1 bit: Gra (IR Ra field), Grb (IR Rb field), BAout (base-address out, R0 reads 0).
REQ-005 The block SHALL have bus source select inputs, each 1 bit: PC_select, Z_LO_select, MDR_select, c_select (sign-extended constant), r_select (GPR out).
REQ-006 The block SHALL have alu_instruction in 5 (ALU opcode).
REQ-007 The block SHALL have bus_select out 5 (encoded bus source) and register_select out 16 (one-hot decoded GPR).
REQ-008 The block SHALL have these 32-bit outputs: bus_Data, R2_Data, R3_Data, PC_Data, IR_Data, Y_Data, Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data, MDataIN (memory read data).

Function
REQ-009 The block SHALL contain 16 32-bit GPRs R0-R15 plus PC, IR, Y, MAR, MDR (32-bit) and Z (64-bit: HI = Z_HI_Data, LO = Z_LO_Data).
REQ-010 IR field decode SHALL be: Ra = IR[26:23], Rb = IR[22:19], C = IR[18:0] sign-extended to 32 bits.
REQ-011 register_select SHALL be the one-hot decode of (Gra ? Ra : 0) | (Grb ? Rb : 0); it is 0 when neither Gra nor Grb is set.
REQ-012 bus_select encoding SHALL be: 18 PC, 17 Z_LO, 19 MDR, 20 C, 0-15 selected GPR (when r_select or BAout is set), 31 none.
REQ-013 Bus source priority SHALL be PC > Z_LO > MDR > C > GPR; with no source selected, bus_Data = 0.
REQ-014 With BAout set and R0 selected, the bus SHALL carry 0 regardless of R0 contents.
REQ-015 Every register with its enable high SHALL load from bus_Data on each rising clk edge; a GPR loads when r_enable is high and its register_select bit is set.
REQ-016 PC SHALL increment by 1 once per 0->1 transition of PC_increment_enable, edge-detected on clk; PC_enable loads PC from the bus and takes precedence over increment.
REQ-017 The MDR input SHALL be MDataIN when read = 1, else bus_Data.
REQ-018 Memory SHALL be a 512x32 array addressed by MAR[8:0], with combinational read to MDataIN and a synchronous write of MDR on the clk edge when write = 1.
REQ-019 Memory initial contents SHALL be: word 0 = 0x09000035 (ldi R2,0x35), word 1 = 0x71900053 (ori R3,R2,0x53); all other words 0.
REQ-020 The ALU SHALL compute Z from A = Y and B = bus_Data, registered into Z on Z_enable.
REQ-021 The ALU opcodes SHALL be (LO result, HI = 0 unless stated): 00000-00011 and 01100 ADD; 00100 SUB; 00101 SHR; 00110 SHRA; 00111 SHL; 01000 ROR; 01001 ROL (shift amount B[4:0]); 01010 and 01101 AND; 01011 and 01110 OR; 01111 MUL (signed 64-bit {HI,LO}); 10000 DIV (LO quotient, HI remainder, divide-by-zero gives 0/0); 10001 NEG B; 10010 NOT B; all others 0.
REQ-022 Arithmetic SHALL be 32-bit two's complement with wrap-around and no flags.

Reset
REQ-023 When reset is asserted, all GPRs, PC, IR, Y, Z, MAR, MDR and the increment edge detector SHALL clear to 0 immediately, mid-instruction included; memory SHALL be unaffected.

Structure
REQ-024 Opcode constants and bus_select codes SHALL be defined in a shared package cpu_pkg.
REQ-025 The ALU SHALL be a single sub-module, alu; the registers, bus mux, select/encode logic and memory SHALL stay in cpu_datapath.

Verification
REQ-026 Scenario: reset; PC_select + MAR_enable; then read + MDR_enable + PC_increment_enable held 4 cycles -> MDR = 0x09000035, PC = 1 (single increment).
REQ-027 Scenario: ldi sequence (T3 Grb + BAout into Y; T4 c_select, alu 00001, Z_enable; T5 Z_LO_select, Gra, r_enable) -> Y = 0, R2 = 0x35, register_select = 0x0004 during T5.
REQ-028 Scenario: ori sequence (T3 C into Y; T4 Grb + r_select, alu 01110; T5 write Ra) -> R3 = 0x00000077, PC = 2.
REQ-029 Scenario: Y = 0xFFFFFFFE, bus = 3, alu 01111 -> Z_HI = 0xFFFFFFFF, Z_LO = 0xFFFFFFFA; alu 10000 with Y = 7, bus = 2 -> LO = 3, HI = 1.
REQ-030 Scenario: PC_select and MDR_select asserted together -> bus_select = 18, bus = PC; no select asserted -> bus_select = 31, bus = 0.
REQ-031 Scenario: reset asserted between clock edges mid-sequence -> all registers read 0 immediately; memory word 1 still reads 0x71900053.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU datapath: bus source codes, ALU opcodes,
// and the power-on memory image.
package cpu_pkg;

    localparam int MEM_WORDS = 512;

    typedef logic [31:0] word_t;

    localparam logic [4:0] BUS_ZLO  = 5'd17;
    localparam logic [4:0] BUS_PC   = 5'd18;
    localparam logic [4:0] BUS_MDR  = 5'd19;
    localparam logic [4:0] BUS_C    = 5'd20;
    localparam logic [4:0] BUS_NONE = 5'd31;

    localparam logic [4:0] ALU_ADD0 = 5'b00000;
    localparam logic [4:0] ALU_ADD1 = 5'b00001;
    localparam logic [4:0] ALU_ADD2 = 5'b00010;
    localparam logic [4:0] ALU_ADD3 = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_SHR  = 5'b00101;
    localparam logic [4:0] ALU_SHRA = 5'b00110;
    localparam logic [4:0] ALU_SHL  = 5'b00111;
    localparam logic [4:0] ALU_ROR  = 5'b01000;
    localparam logic [4:0] ALU_ROL  = 5'b01001;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_OR   = 5'b01011;
    localparam logic [4:0] ALU_ADDI = 5'b01100;
    localparam logic [4:0] ALU_ANDI = 5'b01101;
    localparam logic [4:0] ALU_ORI  = 5'b01110;
    localparam logic [4:0] ALU_MUL  = 5'b01111;
    localparam logic [4:0] ALU_DIV  = 5'b10000;
    localparam logic [4:0] ALU_NEG  = 5'b10001;
    localparam logic [4:0] ALU_NOT  = 5'b10010;

    // Boot program: ldi R2,0x35 ; ori R3,R2,0x53
    function automatic word_t mem_init(input logic [8:0] addr);
        case (addr)
            9'd0:    return 32'h0900_0035;
            9'd1:    return 32'h7190_0053;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit {hi,lo} result.
module alu
    import cpu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [4:0]  sh;
    logic [63:0] rot;
    logic [63:0] prod;

    assign sh = b[4:0];

    always_comb begin
        hi   = '0;
        lo   = '0;
        rot  = '0;
        prod = '0;
        case (op)
            ALU_ADD0, ALU_ADD1, ALU_ADD2, ALU_ADD3, ALU_ADDI:
                lo = a + b;
            ALU_SUB:  lo = a - b;
            ALU_SHR:  lo = a >> sh;
            ALU_SHRA: lo = $unsigned($signed(a) >>> sh);
            ALU_SHL:  lo = a << sh;
            // Rotates shift a doubled copy so a zero amount needs no special case
            ALU_ROR: begin
                rot = {a, a} >> sh;
                lo  = rot[31:0];
            end
            ALU_ROL: begin
                rot = {a, a} << sh;
                lo  = rot[63:32];
            end
            ALU_AND, ALU_ANDI: lo = a & b;
            ALU_OR, ALU_ORI:   lo = a | b;
            ALU_MUL: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                hi   = prod[63:32];
                lo   = prod[31:0];
            end
            ALU_DIV: begin
                if (b != 32'd0) begin
                    lo = $unsigned($signed(a) / $signed(b));
                    hi = $unsigned($signed(a) % $signed(b));
                end
            end
            ALU_NEG: lo = -b;
            ALU_NOT: lo = ~b;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: GPRs, PC/IR/Y/Z/MAR/MDR, bus mux and 512x32 memory.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_enable,
    input  logic        PC_increment_enable,
    input  logic        IR_enable,
    input  logic        Y_enable,
    input  logic        Z_enable,
    input  logic        MAR_enable,
    input  logic        MDR_enable,
    input  logic        r_enable,
    input  logic        read,
    input  logic        write,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        BAout,
    input  logic        PC_select,
    input  logic        Z_LO_select,
    input  logic        MDR_select,
    input  logic        c_select,
    input  logic        r_select,
    input  logic [4:0]  alu_instruction,
    output logic [4:0]  bus_select,
    output logic [15:0] register_select,
    output logic [31:0] bus_Data,
    output logic [31:0] R2_Data,
    output logic [31:0] R3_Data,
    output logic [31:0] PC_Data,
    output logic [31:0] IR_Data,
    output logic [31:0] Y_Data,
    output logic [31:0] Z_HI_Data,
    output logic [31:0] Z_LO_Data,
    output logic [31:0] MAR_Data,
    output logic [31:0] MDR_Data,
    output logic [31:0] MDataIN
);

    logic [31:0] gpr [16];
    logic [31:0] mem [MEM_WORDS];
    logic        inc_prev;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  reg_idx;
    logic [31:0] c_ext;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic [31:0] mdr_next;
    logic [8:0]  addr;
    logic        unused;

    assign ra      = IR_Data[26:23];
    assign rb      = IR_Data[22:19];
    assign c_ext   = {{13{IR_Data[18]}}, IR_Data[18:0]};
    assign reg_idx = (Gra ? ra : 4'd0) | (Grb ? rb : 4'd0);

    assign register_select = (Gra || Grb) ? (16'd1 << reg_idx) : 16'd0;

    assign R2_Data = gpr[2];
    assign R3_Data = gpr[3];

    always_comb begin
        bus_select = BUS_NONE;
        bus_Data   = '0;
        if (PC_select) begin
            bus_select = BUS_PC;
            bus_Data   = PC_Data;
        end else if (Z_LO_select) begin
            bus_select = BUS_ZLO;
            bus_Data   = Z_LO_Data;
        end else if (MDR_select) begin
            bus_select = BUS_MDR;
            bus_Data   = MDR_Data;
        end else if (c_select) begin
            bus_select = BUS_C;
            bus_Data   = c_ext;
        end else if (r_select || BAout) begin
            bus_select = {1'b0, reg_idx};
            bus_Data   = (BAout && reg_idx == 4'd0) ? 32'd0 : gpr[reg_idx];
        end
    end

    alu u_alu (
        .op (alu_instruction),
        .a  (Y_Data),
        .b  (bus_Data),
        .hi (alu_hi),
        .lo (alu_lo)
    );

    // Array holds data XOR boot image, so the all-zero power-up state
    // reads back as the boot program without a reset path into memory.
    assign addr     = MAR_Data[8:0];
    assign MDataIN  = mem[addr] ^ mem_init(addr);
    assign mdr_next = read ? MDataIN : bus_Data;
    assign unused   = &{1'b0, MAR_Data[31:9]};

    always_ff @(posedge clk) begin
        if (write) begin
            mem[addr] <= MDR_Data ^ mem_init(addr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_Data   <= '0;
            IR_Data   <= '0;
            Y_Data    <= '0;
            Z_HI_Data <= '0;
            Z_LO_Data <= '0;
            MAR_Data  <= '0;
            MDR_Data  <= '0;
            inc_prev  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            if (PC_enable) begin
                PC_Data <= bus_Data;
            end else if (PC_increment_enable && !inc_prev) begin
                PC_Data <= PC_Data + 32'd1;
            end
            inc_prev <= PC_increment_enable;
            if (IR_enable) begin
                IR_Data <= bus_Data;
            end
            if (Y_enable) begin
                Y_Data <= bus_Data;
            end
            if (Z_enable) begin
                Z_HI_Data <= alu_hi;
                Z_LO_Data <= alu_lo;
            end
            if (MAR_enable) begin
                MAR_Data <= bus_Data;
            end
            if (MDR_enable) begin
                MDR_Data <= mdr_next;
            end
            for (int i = 0; i < 16; i++) begin
                if (r_enable && register_select[i]) begin
                    gpr[i] <= bus_Data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed instruction sequences plus randomized control cycles vs a reference model.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_enable, PC_increment_enable, IR_enable, Y_enable;
    logic        Z_enable, MAR_enable, MDR_enable, r_enable;
    logic        read, write, Gra, Grb, BAout;
    logic        PC_select, Z_LO_select, MDR_select, c_select, r_select;
    logic [4:0]  alu_instruction;
    logic [4:0]  bus_select;
    logic [15:0] register_select;
    logic [31:0] bus_Data, R2_Data, R3_Data, PC_Data, IR_Data, Y_Data;
    logic [31:0] Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data, MDataIN;

    cpu_datapath dut (
        .clk                 (clk),
        .reset               (reset),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .r_enable            (r_enable),
        .read                (read),
        .write               (write),
        .Gra                 (Gra),
        .Grb                 (Grb),
        .BAout               (BAout),
        .PC_select           (PC_select),
        .Z_LO_select         (Z_LO_select),
        .MDR_select          (MDR_select),
        .c_select            (c_select),
        .r_select            (r_select),
        .alu_instruction     (alu_instruction),
        .bus_select          (bus_select),
        .register_select     (register_select),
        .bus_Data            (bus_Data),
        .R2_Data             (R2_Data),
        .R3_Data             (R3_Data),
        .PC_Data             (PC_Data),
        .IR_Data             (IR_Data),
        .Y_Data              (Y_Data),
        .Z_HI_Data           (Z_HI_Data),
        .Z_LO_Data           (Z_LO_Data),
        .MAR_Data            (MAR_Data),
        .MDR_Data            (MDR_Data),
        .MDataIN             (MDataIN)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] m_gpr [16];
    logic [31:0] m_mem [512];
    logic [31:0] m_pc, m_ir, m_y, m_zhi, m_zlo, m_mar, m_mdr;
    logic        m_prev;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_pc = '0; m_ir = '0; m_y = '0; m_zhi = '0; m_zlo = '0;
        m_mar = '0; m_mdr = '0; m_prev = 1'b0;
    endtask

    function automatic logic [63:0] ref_alu(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        logic [31:0] lo, hi;
        longint p;
        s = int'(b[4:0]);
        lo = '0;
        hi = '0;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
            5'd4:  lo = a - b;
            5'd5:  lo = a >> s;
            5'd6:  lo = $unsigned(signed'(a) >>> s);
            5'd7:  lo = a << s;
            5'd8:  lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            5'd9:  lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            5'd10, 5'd13: lo = a & b;
            5'd11, 5'd14: lo = a | b;
            5'd15: begin
                p = longint'(signed'(a)) * longint'(signed'(b));
                {hi, lo} = p;
            end
            5'd16: begin
                if (b != 0) begin
                    lo = $unsigned(signed'(a) / signed'(b));
                    hi = $unsigned(signed'(a) % signed'(b));
                end
            end
            5'd17: lo = 32'd0 - b;
            5'd18: lo = ~b;
            default: ;
        endcase
        return {hi, lo};
    endfunction

    task automatic model_comb(output logic [4:0] sel, output logic [31:0] bus,
                              output logic [15:0] rs, output logic [31:0] mdin);
        logic [3:0] idx;
        idx = (Gra ? m_ir[26:23] : 4'd0) | (Grb ? m_ir[22:19] : 4'd0);
        rs = (Gra || Grb) ? (16'd1 << idx) : 16'd0;
        mdin = m_mem[m_mar[8:0]];
        sel = 5'd31;
        bus = '0;
        if (PC_select) begin
            sel = 5'd18; bus = m_pc;
        end else if (Z_LO_select) begin
            sel = 5'd17; bus = m_zlo;
        end else if (MDR_select) begin
            sel = 5'd19; bus = m_mdr;
        end else if (c_select) begin
            sel = 5'd20; bus = 32'(signed'(m_ir[18:0]));
        end else if (r_select || BAout) begin
            sel = {1'b0, idx};
            bus = (BAout && idx == 0) ? 32'd0 : m_gpr[idx];
        end
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, "_PC"}, PC_Data, m_pc);
        chk({pfx, "_IR"}, IR_Data, m_ir);
        chk({pfx, "_Y"}, Y_Data, m_y);
        chk({pfx, "_ZHI"}, Z_HI_Data, m_zhi);
        chk({pfx, "_ZLO"}, Z_LO_Data, m_zlo);
        chk({pfx, "_MAR"}, MAR_Data, m_mar);
        chk({pfx, "_MDR"}, MDR_Data, m_mdr);
        chk({pfx, "_R2"}, R2_Data, m_gpr[2]);
        chk({pfx, "_R3"}, R3_Data, m_gpr[3]);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_PC"}, PC_Data, 0);
        chk({pfx, "_IR"}, IR_Data, 0);
        chk({pfx, "_Y"}, Y_Data, 0);
        chk({pfx, "_ZHI"}, Z_HI_Data, 0);
        chk({pfx, "_ZLO"}, Z_LO_Data, 0);
        chk({pfx, "_MAR"}, MAR_Data, 0);
        chk({pfx, "_MDR"}, MDR_Data, 0);
        chk({pfx, "_R2"}, R2_Data, 0);
        chk({pfx, "_R3"}, R3_Data, 0);
    endtask

    task automatic clear_ctl();
        PC_enable = 0; PC_increment_enable = 0; IR_enable = 0; Y_enable = 0;
        Z_enable = 0; MAR_enable = 0; MDR_enable = 0; r_enable = 0;
        read = 0; write = 0; Gra = 0; Grb = 0; BAout = 0;
        PC_select = 0; Z_LO_select = 0; MDR_select = 0; c_select = 0;
        r_select = 0; alu_instruction = '0;
    endtask

    // Called in the low clock phase with controls set; returns at next negedge.
    task automatic step();
        logic [4:0]  sel;
        logic [31:0] bus, mdin;
        logic [15:0] rs;
        logic [63:0] z;
        #1;
        model_comb(sel, bus, rs, mdin);
        chk("bus_select", bus_select, sel);
        chk("bus_Data", bus_Data, bus);
        chk("register_select", register_select, rs);
        chk("MDataIN", MDataIN, mdin);
        z = ref_alu(alu_instruction, m_y, bus);
        @(posedge clk);
        #1;
        if (write) m_mem[m_mar[8:0]] = m_mdr;
        if (PC_enable) m_pc = bus;
        else if (PC_increment_enable && !m_prev) m_pc = m_pc + 1;
        m_prev = PC_increment_enable;
        if (IR_enable) m_ir = bus;
        if (Y_enable) m_y = bus;
        if (Z_enable) {m_zhi, m_zlo} = z;
        if (MAR_enable) m_mar = bus;
        if (MDR_enable) m_mdr = read ? mdin : bus;
        for (int i = 0; i < 16; i++)
            if (r_enable && rs[i]) m_gpr[i] = bus;
        check_regs("reg");
        @(negedge clk);
    endtask

    task automatic fetch();
        clear_ctl(); PC_select = 1; MAR_enable = 1; step();
        clear_ctl(); read = 1; MDR_enable = 1; PC_increment_enable = 1;
        repeat (4) step();
        clear_ctl(); MDR_select = 1; IR_enable = 1; step();
    endtask

    task automatic pulse_inc();
        clear_ctl(); PC_increment_enable = 1; step();
        clear_ctl(); step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  sel;
        logic [31:0] bus, mdin;
        logic [15:0] rs;
        for (int i = 0; i < 512; i++) m_mem[i] = '0;
        m_mem[0] = 32'h0900_0035;
        m_mem[1] = 32'h7190_0053;
        model_reset();
        clear_ctl();
        reset = 1;
        repeat (2) @(negedge clk);
        #1;
        check_zero("rst");
        reset = 0;
        @(negedge clk);

        // fetch ldi: MDR and single PC increment
        clear_ctl(); PC_select = 1; MAR_enable = 1; step();
        clear_ctl(); read = 1; MDR_enable = 1; PC_increment_enable = 1;
        repeat (4) step();
        chk("fetch0_MDR", MDR_Data, 32'h0900_0035);
        chk("fetch0_PC", PC_Data, 32'd1);
        clear_ctl(); MDR_select = 1; IR_enable = 1; step();

        // ldi R2,0x35
        clear_ctl(); Grb = 1; BAout = 1; Y_enable = 1; step();
        chk("ldi_Y", Y_Data, 32'd0);
        clear_ctl(); c_select = 1; alu_instruction = 5'b00001; Z_enable = 1; step();
        clear_ctl(); Z_LO_select = 1; Gra = 1; r_enable = 1;
        #1;
        chk("ldi_regsel", register_select, 16'h0004);
        step();
        chk("ldi_R2", R2_Data, 32'h35);

        // ori R3,R2,0x53
        fetch();
        chk("fetch1_IR", IR_Data, 32'h7190_0053);
        clear_ctl(); c_select = 1; Y_enable = 1; step();
        clear_ctl(); Grb = 1; r_select = 1; alu_instruction = 5'b01110; Z_enable = 1; step();
        clear_ctl(); Z_LO_select = 1; Gra = 1; r_enable = 1; step();
        chk("ori_R3", R3_Data, 32'h77);
        chk("ori_PC", PC_Data, 32'd2);

        // MUL: Y = -2 (NEG of PC=2), bus = 3
        clear_ctl(); PC_select = 1; Grb = 1; r_enable = 1; step();
        clear_ctl(); PC_select = 1; alu_instruction = 5'b10001; Z_enable = 1; step();
        clear_ctl(); Z_LO_select = 1; Y_enable = 1; step();
        chk("mul_Y", Y_Data, 32'hFFFF_FFFE);
        pulse_inc();
        clear_ctl(); PC_select = 1; alu_instruction = 5'b01111; Z_enable = 1; step();
        chk("mul_HI", Z_HI_Data, 32'hFFFF_FFFF);
        chk("mul_LO", Z_LO_Data, 32'hFFFF_FFFA);

        // DIV: Y = 7, bus = R2 = 2
        repeat (4) pulse_inc();
        clear_ctl(); PC_select = 1; Y_enable = 1; step();
        chk("div_Y", Y_Data, 32'd7);
        clear_ctl(); Grb = 1; r_select = 1; alu_instruction = 5'b10000; Z_enable = 1; step();
        chk("div_LO", Z_LO_Data, 32'd3);
        chk("div_HI", Z_HI_Data, 32'd1);

        // bus priority and idle bus
        clear_ctl(); PC_select = 1; MDR_select = 1;
        #1;
        chk("prio_sel", bus_select, 5'd18);
        chk("prio_bus", bus_Data, 32'd7);
        step();
        clear_ctl();
        #1;
        chk("idle_sel", bus_select, 5'd31);
        chk("idle_bus", bus_Data, 32'd0);
        step();

        // async reset in the middle of a fetch
        clear_ctl(); PC_select = 1; MAR_enable = 1; step();
        clear_ctl(); read = 1; MDR_enable = 1; step();
        clear_ctl();
        #2;
        reset = 1;
        #1;
        check_zero("midrst");
        model_reset();
        #1;
        reset = 0;
        @(negedge clk);
        pulse_inc();
        clear_ctl(); PC_select = 1; MAR_enable = 1; step();
        #1;
        chk("mem1_kept", MDataIN, 32'h7190_0053);
        step();

        // randomized control cycles
        for (int i = 0; i < 600; i++) begin
            clear_ctl();
            PC_enable = ($urandom_range(0, 7) == 0);
            PC_increment_enable = $urandom_range(0, 1) == 1;
            IR_enable = ($urandom_range(0, 3) == 0);
            Y_enable = ($urandom_range(0, 2) == 0);
            Z_enable = ($urandom_range(0, 1) == 1);
            MAR_enable = ($urandom_range(0, 3) == 0);
            MDR_enable = ($urandom_range(0, 2) == 0);
            r_enable = ($urandom_range(0, 2) == 0);
            read = $urandom_range(0, 1) == 1;
            write = ($urandom_range(0, 5) == 0);
            Gra = $urandom_range(0, 1) == 1;
            Grb = $urandom_range(0, 1) == 1;
            BAout = ($urandom_range(0, 4) == 0);
            PC_select = ($urandom_range(0, 5) == 0);
            Z_LO_select = ($urandom_range(0, 3) == 0);
            MDR_select = ($urandom_range(0, 3) == 0);
            c_select = ($urandom_range(0, 3) == 0);
            r_select = $urandom_range(0, 1) == 1;
            alu_instruction = 5'($urandom_range(0, 20));
            model_comb(sel, bus, rs, mdin);
            if (alu_instruction == 5'd16 && m_y == 32'h8000_0000 &&
                bus == 32'hFFFF_FFFF)
                alu_instruction = 5'd0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
